// File: rtl/wmc_timer_pkg.sv
// Purpose: shared phase codes, FSM encoding, cfg_sel codes, default durations, actuator decode.
// Latency: n/a (constants and a combinational helper function).
// Backpressure: n/a.
package wmc_timer_pkg;

    // Latched phase codes. PH_FAULT also serves as the "illegal" decode result.
    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_DRAIN = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_FAULT = 3'd7;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Duration register select codes; 5..7 select nothing
    localparam logic [2:0] SEL_FILL  = 3'd0;
    localparam logic [2:0] SEL_WASH  = 3'd1;
    localparam logic [2:0] SEL_DRAIN = 3'd2;
    localparam logic [2:0] SEL_RINSE = 3'd3;
    localparam logic [2:0] SEL_SPIN  = 3'd4;

    // Default geometry and durations (ticks)
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_PRESCALE = 1000;
    localparam int DEF_T_FILL   = 30;
    localparam int DEF_T_WASH   = 120;
    localparam int DEF_T_DRAIN  = 20;
    localparam int DEF_T_RINSE  = 60;
    localparam int DEF_T_SPIN   = 90;

    // Actuator pattern -> phase. Exact-match patterns only; anything else is illegal.
    function automatic logic [2:0] decode_phase(input logic water_fill, input logic agitator,
                                                input logic motor, input logic pump,
                                                input logic speed);
        logic [4:0] act;
        act = {water_fill, agitator, motor, pump, speed};
        case (act)
            5'b00000: decode_phase = PH_IDLE;
            5'b10000: decode_phase = PH_FILL;
            5'b01100: decode_phase = PH_WASH;
            5'b00010: decode_phase = PH_DRAIN;
            5'b00101: decode_phase = PH_SPIN;
            default:  decode_phase = PH_FAULT;
        endcase
    endfunction

endpackage

// File: rtl/wmc_prescaler.sv
// Purpose: PRESCALE-cycle tick generator (count down PRESCALE-1..0, tick on 0) with sync clear and hold.
// Latency: first tick PRESCALE cycles after clear; tick is combinational from the count.
// Backpressure: hold freezes the count and suppresses tick.
// Ports: clk, rst_n (async active-low), clr (reload to PRESCALE-1), hold, tick (out).
module wmc_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == '0) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LAST;
        end else if (clr) begin
            cnt <= LAST;
        end else if (!hold) begin
            cnt <= (cnt == '0) ? LAST : cnt - CW'(1);
        end
    end

endmodule

// File: rtl/wash_cycle_timer.sv
// Purpose: decode actuators to a wash phase, time it against programmable durations, pulse completion.
// Latency: load on first edge decode differs from latched phase; done pulse at load edge + D*PRESCALE + 1.
// Backpressure: none; with WMC_PAUSE_EN, pause freezes prescaler and remaining while in RUN.
// Ports: clk, rst_n, actuator inputs, cfg_we/cfg_sel/cfg_data, [pause], t* pulses, busy, phase, remaining, fault.
module wash_cycle_timer
    import wmc_timer_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int T_FILL   = DEF_T_FILL,
    parameter int T_WASH   = DEF_T_WASH,
    parameter int T_DRAIN  = DEF_T_DRAIN,
    parameter int T_RINSE  = DEF_T_RINSE,
    parameter int T_SPIN   = DEF_T_SPIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             water_fill,
    input  logic             agitator,
    input  logic             motor,
    input  logic             pump,
    input  logic             speed,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
`ifdef WMC_PAUSE_EN
    input  logic             pause,
`endif
    output logic             tfill,
    output logic             twash,
    output logic             tdrain,
    output logic             trinse,
    output logic             tspin,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             fault
);

    logic [1:0]       state;
    logic [1:0]       wash_cnt;   // saturates at 2: 0 none, 1 first wash seen, 2 rinse(s) seen
    logic             rinse_q;    // current WASH load used the rinse duration
    logic [CNT_W-1:0] dur_fill, dur_wash, dur_drain, dur_rinse, dur_spin;
    logic [CNT_W-1:0] load_dur;
    logic [2:0]       dec;
    logic             changed, load_en, wash_rinse, hold, tick;

`ifdef WMC_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign dec        = decode_phase(water_fill, agitator, motor, pump, speed);
    // FAULT only exits on IDLE decode, so it never takes the generic change path.
    assign changed    = (state != ST_FAULT) && (dec != phase);
    assign load_en    = changed && (dec != PH_IDLE) && (dec != PH_FAULT);
    // The counter is being cleared while in IDLE, so a wash entered from IDLE is always the first.
    assign wash_rinse = (state != ST_IDLE) && (wash_cnt != 2'd0);
    assign busy       = (state == ST_RUN);
    assign fault      = (state == ST_FAULT);

    always_comb begin
        load_dur = '0;
        case (dec)
            PH_FILL:  load_dur = dur_fill;
            PH_WASH:  load_dur = wash_rinse ? dur_rinse : dur_wash;
            PH_DRAIN: load_dur = dur_drain;
            PH_SPIN:  load_dur = dur_spin;
            default:  load_dur = '0;
        endcase
    end

    wmc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_en),
        .hold  (hold),
        .tick  (tick)
    );

    // Duration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_fill  <= CNT_W'(T_FILL);
            dur_wash  <= CNT_W'(T_WASH);
            dur_drain <= CNT_W'(T_DRAIN);
            dur_rinse <= CNT_W'(T_RINSE);
            dur_spin  <= CNT_W'(T_SPIN);
        end else if (cfg_we) begin
            case (cfg_sel)
                SEL_FILL:  dur_fill  <= cfg_data;
                SEL_WASH:  dur_wash  <= cfg_data;
                SEL_DRAIN: dur_drain <= cfg_data;
                SEL_RINSE: dur_rinse <= cfg_data;
                SEL_SPIN:  dur_spin  <= cfg_data;
                default: ;
            endcase
        end
    end

    // Wash entry counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wash_cnt <= 2'd0;
        end else if (load_en && (dec == PH_WASH)) begin
            wash_cnt <= wash_rinse ? 2'd2 : 2'd1;
        end else if (state == ST_IDLE) begin
            wash_cnt <= 2'd0;
        end
    end

    // Phase FSM, remaining counter and done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= PH_IDLE;
            remaining <= '0;
            rinse_q   <= 1'b0;
            tfill     <= 1'b0;
            twash     <= 1'b0;
            tdrain    <= 1'b0;
            trinse    <= 1'b0;
            tspin     <= 1'b0;
        end else begin
            tfill  <= 1'b0;
            twash  <= 1'b0;
            tdrain <= 1'b0;
            trinse <= 1'b0;
            tspin  <= 1'b0;
            if (changed) begin
                // A decode change takes priority over any expiry on the same edge.
                if (dec == PH_IDLE) begin
                    state     <= ST_IDLE;
                    phase     <= PH_IDLE;
                    remaining <= '0;
                end else if (dec == PH_FAULT) begin
                    state     <= ST_FAULT;
                    phase     <= PH_FAULT;
                    remaining <= '0;
                end else begin
                    state     <= ST_RUN;
                    phase     <= dec;
                    remaining <= load_dur;
                    rinse_q   <= (dec == PH_WASH) && wash_rinse;
                end
            end else if (state == ST_FAULT) begin
                if (dec == PH_IDLE) begin
                    state <= ST_IDLE;
                    phase <= PH_IDLE;
                end
            end else if ((state == ST_RUN) && !hold) begin
                if (remaining == '0) begin
                    state <= ST_DONE;
                    case (phase)
                        PH_FILL:  tfill <= 1'b1;
                        PH_WASH: begin
                            twash  <= 1'b1;
                            trinse <= rinse_q;
                        end
                        PH_DRAIN: tdrain <= 1'b1;
                        PH_SPIN:  tspin  <= 1'b1;
                        default: ;
                    endcase
                end else if (tick) begin
                    remaining <= remaining - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wash_cycle_timer.sv
module tb_wash_cycle_timer;

    localparam int P = 4;
    localparam int CNT_W = 16;

    localparam logic [4:0] A_IDLE  = 5'b00000;
    localparam logic [4:0] A_FILL  = 5'b10000;
    localparam logic [4:0] A_WASH  = 5'b01100;
    localparam logic [4:0] A_DRAIN = 5'b00010;
    localparam logic [4:0] A_SPIN  = 5'b00101;
    localparam logic [4:0] A_BAD   = 5'b10010;

    // pulse vector order {tfill, twash, tdrain, trinse, tspin}
    localparam logic [4:0] V_FILL  = 5'b10000;
    localparam logic [4:0] V_WASH  = 5'b01000;
    localparam logic [4:0] V_DRAIN = 5'b00100;
    localparam logic [4:0] V_RINSE = 5'b01010;
    localparam logic [4:0] V_SPIN  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic water_fill = 1'b0, agitator = 1'b0, motor = 1'b0, pump = 1'b0, speed = 1'b0;
    logic cfg_we = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic [CNT_W-1:0] cfg_data = '0;
    logic pause = 1'b0;
    logic tfill, twash, tdrain, trinse, tspin, busy, fault;
    logic [2:0] phase;
    logic [CNT_W-1:0] remaining;
    logic [4:0] pulses;

    wash_cycle_timer #(
        .CNT_W(CNT_W), .PRESCALE(P),
        .T_FILL(3), .T_WASH(5), .T_DRAIN(2), .T_RINSE(4), .T_SPIN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .water_fill(water_fill), .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
`ifdef WMC_PAUSE_EN
        .pause(pause),
`endif
        .tfill(tfill), .twash(twash), .tdrain(tdrain), .trinse(trinse), .tspin(tspin),
        .busy(busy), .phase(phase), .remaining(remaining), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign pulses = {tfill, twash, tdrain, trinse, tspin};

    typedef struct {
        logic [4:0] vec;
        int         edge_no;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every pulse seen must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (pulses !== 5'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {27'd0, pulses}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_vec", {27'd0, pulses}, {27'd0, e.vec});
                check("pulse_edge", cyc, e.edge_no);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] a);
        {water_fill, agitator, motor, pump, speed} = a;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [CNT_W-1:0] data);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_data = data;
        step(1);
        cfg_we = 1'b0;
    endtask

    // Enter a phase, expect its pulse at load edge + d*P + 1, and advance to that edge.
    task automatic run_phase(input logic [4:0] act, input int d, input logic [4:0] vec,
                             input logic [2:0] ph);
        int l;
        drive(act);
        l = cyc + 1;
        sb.push_back('{vec, l + d * P + 1});
        step(1);
        check("load_phase", {29'd0, phase}, {29'd0, ph});
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_rem", {16'd0, remaining}, d);
        step(d * P + 1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_rem", {16'd0, remaining}, 32'd0);
    endtask

    initial begin
        int l;
        // Reset state
        step(2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_phase", {29'd0, phase}, 32'd0);
        check("rst_rem", {16'd0, remaining}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_pulses", {27'd0, pulses}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Fill with remaining stepping on ticks
        drive(A_FILL);
        l = cyc + 1;
        sb.push_back('{V_FILL, l + 3 * P + 1});
        step(1);
        check("fill_rem3", {16'd0, remaining}, 32'd3);
        check("fill_phase", {29'd0, phase}, 32'd1);
        step(3);
        check("fill_rem3_hold", {16'd0, remaining}, 32'd3);
        step(1);
        check("fill_rem2", {16'd0, remaining}, 32'd2);
        step(4);
        check("fill_rem1", {16'd0, remaining}, 32'd1);
        step(4);
        check("fill_rem0", {16'd0, remaining}, 32'd0);
        check("fill_busy_at0", {31'd0, busy}, 32'd1);
        step(1);
        check("fill_done_busy", {31'd0, busy}, 32'd0);
        check("fill_done_phase", {29'd0, phase}, 32'd1);

        // Full program; second wash is a rinse
        run_phase(A_WASH, 5, V_WASH, 3'd2);
        run_phase(A_DRAIN, 2, V_DRAIN, 3'd3);
        run_phase(A_FILL, 3, V_FILL, 3'd1);
        run_phase(A_WASH, 4, V_RINSE, 3'd2);
        run_phase(A_DRAIN, 2, V_DRAIN, 3'd3);
        run_phase(A_SPIN, 2, V_SPIN, 3'd4);
        drive(A_IDLE);
        step(1);
        check("seq_idle_phase", {29'd0, phase}, 32'd0);
        check("seq_idle_busy", {31'd0, busy}, 32'd0);

        // Zero wash duration; an out-of-range select must not land anywhere
        cfg_write(3'd1, 16'd0);
        cfg_write(3'd5, 16'd9);
        step(1);
        run_phase(A_WASH, 0, V_WASH, 3'd2);
        drive(A_IDLE);
        step(2);

        // Phase change mid-run abandons fill, drain timed from its own load
        drive(A_FILL);
        step(3);
        run_phase(A_DRAIN, 2, V_DRAIN, 3'd3);
        drive(A_IDLE);
        step(2);

        // Abort fill to IDLE with remaining 2
        drive(A_FILL);
        step(5);
        check("abort_rem2", {16'd0, remaining}, 32'd2);
        drive(A_IDLE);
        step(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_phase", {29'd0, phase}, 32'd0);
        step(15);

        // Illegal actuator combination
        drive(A_BAD);
        step(1);
        check("fault_flag", {31'd0, fault}, 32'd1);
        check("fault_phase", {29'd0, phase}, 32'd7);
        check("fault_busy", {31'd0, busy}, 32'd0);
        drive(A_FILL);
        step(2);
        check("fault_sticky", {31'd0, fault}, 32'd1);
        drive(A_IDLE);
        step(1);
        check("fault_clear", {31'd0, fault}, 32'd0);
        check("fault_clear_phase", {29'd0, phase}, 32'd0);
        step(1);

`ifdef WMC_PAUSE_EN
        // Pause 10 cycles mid-spin delays tspin by exactly 10
        drive(A_SPIN);
        l = cyc + 1;
        sb.push_back('{V_SPIN, l + 2 * P + 1 + 10});
        step(3);
        pause = 1'b1;
        step(10);
        check("pause_busy", {31'd0, busy}, 32'd1);
        check("pause_rem", {16'd0, remaining}, 32'd2);
        pause = 1'b0;
        step(l + 2 * P + 1 + 10 - cyc);
        check("pause_done_busy", {31'd0, busy}, 32'd0);
        drive(A_IDLE);
        step(2);
`endif

        // Reset mid-run: no pulse, outputs cleared, durations back to defaults
        cfg_write(3'd0, 16'd1);
        drive(A_FILL);
        step(1);
        check("pre_rst_rem", {16'd0, remaining}, 32'd1);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rem", {16'd0, remaining}, 32'd0);
        check("mid_rst_phase", {29'd0, phase}, 32'd0);
        check("mid_rst_pulses", {27'd0, pulses}, 32'd0);
        drive(A_IDLE);
        step(2);
        rst_n = 1'b1;
        step(1);
        run_phase(A_FILL, 3, V_FILL, 3'd1);
        run_phase(A_WASH, 5, V_WASH, 3'd2);
        drive(A_IDLE);
        step(3);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_cycle_timer.md
# wash_cycle_timer

Phase timer and scheduler for the washing machine controller. It decodes the controller's actuator outputs (water_fill, agitator, motor, pump, speed) into the active wash phase, times each phase against programmable durations, and returns one-cycle completion pulses (tfill, twash, tdrain, trinse, tspin) that advance the controller. Running counters, per-phase duration registers and a fault flag for illegal actuator combinations are all implemented here.

## Interface
- CNT_W, 16: width of the duration registers and the remaining-time counter.
- PRESCALE, 1000: clk cycles per time tick; must be ≥ 1.
- T_FILL / T_WASH / T_DRAIN / T_RINSE / T_SPIN, 30 / 120 / 20 / 60 / 90: reset values of the duration registers, in ticks.
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- water_fill, agitator, motor, pump, speed  in  1 each  controller actuator outputs.
- cfg_we  in  1  duration register write strobe.
- cfg_sel  in  3  register select: 0 fill, 1 wash, 2 drain, 3 rinse, 4 spin; 5–7 ignored.
- cfg_data  in  CNT_W  write data.
- pause  in  1  freeze timing. Present only with WMC_PAUSE_EN.
- tfill, twash, tdrain, trinse, tspin  out  1 each  one-cycle completion pulses.
- busy  out  1  high in RUN.
- phase  out  3  latched phase: 0 idle, 1 fill, 2 wash, 3 drain, 4 spin, 7 fault.
- remaining  out  CNT_W  ticks left in the current phase.
- fault  out  1  illegal actuator combination detected.

## Operation
- Combinational decode, listed in priority order:
  - all inputs 0 → IDLE.
  - water_fill alone → FILL.
  - agitator & motor, with pump, speed and water_fill all 0 → WASH.
  - pump alone → DRAIN.
  - motor & speed, with the others 0 → SPIN.
  - anything else → ILLEGAL.
- The wash counter increments on each WASH entry and clears in IDLE. The first WASH uses T_WASH. The second and later use the rinse duration, and their expiry pulses twash and trinse together.
- FSM states: IDLE, RUN, DONE, FAULT.
- IDLE:
  - Decode of FILL, WASH, DRAIN or SPIN → load remaining from that phase's register, clear the prescaler, go to RUN.
  - Decode of ILLEGAL → FAULT.
- RUN:
  - The prescaler counts down PRESCALE−1..0. Each wrap is a tick, and each tick decrements remaining.
  - The tick that takes remaining to 0 pulses the phase's done output on the next edge and moves to DONE.
  - A loaded duration of 0 pulses on the first edge after the load.
- RUN, decode changes before expiry: abandon the current phase with no pulse.
  - New legal phase → reload for it, stay in RUN.
  - IDLE → go to IDLE.
  - ILLEGAL → go to FAULT.
- DONE: hold remaining = 0 and emit no pulses. The next decode change follows the same rules as IDLE; a change to IDLE returns to IDLE.
- FAULT: fault = 1, phase = 7, no pulses. Return to IDLE only when decode is IDLE.
- Config writes:
  - A write takes effect at the next edge.
  - A write during RUN affects only later loads.
  - A write with cfg_sel 5–7 is dropped.
- Reset values:
  - All pulses 0, busy 0, fault 0, phase 0, remaining 0, wash counter 0, FSM IDLE.
  - Duration registers return to their T_* parameter values.
  - Reset mid-phase aborts with no pulse.

## Timing
- Phase entry is detected and loaded on the first edge where the decode differs from the latched phase. Zero-cycle decode.
- With load at edge L, the done pulse is high for exactly one cycle, starting at edge L + D·PRESCALE + 1 (D = duration ≥ 1). For D = 0 it starts at edge L + 1.
- remaining updates on tick edges only.
- If a phase change and expiry occur on the same edge, the change wins and there is no pulse.

## Configuration
- WMC_PAUSE_EN defined: the pause port exists. While pause = 1 in RUN, the prescaler and remaining hold, busy stays 1, and decode changes are still honoured.
- WMC_PAUSE_EN undefined: no pause port; timing is never frozen.

## Structure
- Package wmc_timer_pkg holds the phase codes, FSM state encoding, cfg_sel codes and the default-duration constants.
- Sub-module wmc_prescaler: PRESCALE-cycle tick generator with synchronous clear and hold (hold tied low unless WMC_PAUSE_EN).

## Test plan
- PRESCALE=4, T_FILL=3, assert water_fill at edge 0 → tfill pulses one cycle at edge 13; remaining steps 3, 2, 1, 0 on ticks.
- Drive the full sequence fill → wash → drain → fill → wash → drain → spin → idle → twash alone on the first wash; twash + trinse together on the second, at T_RINSE timing.
- Write cfg_sel=1, data=0, then enter WASH → twash on the first edge after the load.
- Drop water_fill to IDLE mid-FILL with remaining=2 → no tfill, busy falls, phase=0.
- Assert pump + water_fill together → fault=1, phase=7, no pulses; clear all inputs → IDLE, fault=0.
- With WMC_PAUSE_EN, pause for 10 cycles mid-SPIN (T_SPIN=2, PRESCALE=4) → tspin delayed exactly 10 cycles. Also pulse rst_n low mid-RUN → all outputs reset and durations return to their parameter defaults.
